cnt_bank_arbiter: RTL
=====================

Name: cnt_bank_arbiter

Overview:
Shares the single read/clear access port of the N-entry 32-bit counter bank between R software/debug requesters. Each request is READ, CLEAR or READ_CLEAR on one counter index. Requesters are served round-robin; one transaction is in flight at a time; one shared response channel is tagged with the requester ID. Sits between the counter bank and the register/debug fabric.

Parameters:
N, 1000, number of counters in the bank
R, 4, number of requesters (2..16)
W, 32, counter width
IW, $clog2(N), index width (derived, not overridden)
RW, $clog2(R), requester-ID width (derived)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  R  per-requester request valid
req_ready  out  R  per-requester accept; one-hot or zero
req_op  in  2*R  per-requester op: 01 READ, 10 CLEAR, 11 READ_CLEAR, 00 reserved (treated as READ)
req_idx  in  IW*R  per-requester counter index
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  RW  requester that issued the transaction
rsp_data  out  W  counter value sampled before any clear; 0 for CLEAR
rsp_err  out  1  index out of range (only with CNT_ARB_RANGE_CHK_EN)
bank_sel  out  IW  counter index driven to bank
bank_rd  out  1  read strobe to bank
bank_clr  out  1  clear strobe to bank (bank gives clear priority over increment)
bank_rdata  in  W  combinational read data of bank_sel

Behaviour:
- Reset (rst_n=0, async): state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, bank_sel=0, bank_rd=0, bank_clr=0, round-robin pointer = R-1 (so requester 0 has first priority).
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if any req_valid, grant g = first valid requester searching from ptr+1 upward, modulo R. req_ready[g]=1 combinationally in this cycle; on the edge, capture op/idx/id and set ptr=g. No valid: stay, req_ready=0.
- ACCESS (1 cycle): bank_sel=idx_q; bank_rd=1 if op has read bit; bank_clr=1 if op has clear bit. rsp_data registered from bank_rdata at this edge (pre-clear value). For CLEAR, rsp_data=0.
- RESP: rsp_valid=1; rsp_id, rsp_data, rsp_err stable until rsp_ready=1. The handshake edge returns to IDLE. req_ready=0 throughout ACCESS and RESP.
- Latency: accept -> rsp_valid is 2 cycles. Max throughput is one transaction per 3 cycles with rsp_ready tied high.
- bank_sel holds its last value outside ACCESS. bank_rd/bank_clr are single-cycle pulses, only in ACCESS.
- Fairness: with all R valid continuously, grants cycle 0,1,...,R-1,0. A requester waits at most R-1 transactions.
- Requester dropping req_valid before grant: no effect. Request fields need only be stable in the grant cycle.
- rsp_ready held low: FSM stalls in RESP indefinitely, no new grants.
- rst_n asserted mid-transaction: transaction dropped, no response, bank_clr deasserted immediately (async). A clear not yet at its ACCESS edge is not performed.

Optional Feature:
CNT_ARB_RANGE_CHK_EN defined: in ACCESS, if idx_q >= N, bank_rd=bank_clr=0, rsp_data=0, rsp_err=1. In-range accesses give rsp_err=0.
Not defined: no comparison; rsp_err is tied to 0; bank_sel=idx_q is driven unchecked and strobes fire normally.

Test Plan:
- Reset then single READ: req0 READ idx 5, bank_rdata=0x0000_0123 -> req_ready[0] in grant cycle, bank_rd pulse next cycle with bank_sel=5, rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0x123.
- READ_CLEAR idx 999, bank value 0xFFFF_FFFF -> single bank_clr+bank_rd pulse, rsp_data=0xFFFF_FFFF. Follow-up READ returns the bank's post-clear value (0 or 1 depending on increment).
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one grant every 3 cycles; rsp_id matches order.
- rsp_ready low for 10 cycles in RESP -> rsp_valid and rsp_data stable, req_ready all 0, no bank strobes. Completes on the cycle rsp_ready rises.
- Reset during ACCESS of a CLEAR -> bank_clr falls with rst_n, no rsp_valid after release, next grant goes to requester 0.
- With CNT_ARB_RANGE_CHK_EN, READ idx 1000 (N=1000) -> no bank_rd/bank_clr, rsp_err=1, rsp_data=0. Without the macro, rsp_err stays 0 and bank_sel=1000 with bank_rd pulsed.

Source files
------------

// File: rtl/cnt_bank_arbiter.sv
// ---------------------------------------------------------------------------
// cnt_bank_arbiter
//
// Purpose:
//   Shares the single read/clear access port of an N-entry counter bank
//   between R software/debug requesters. Each request is READ, CLEAR or
//   READ_CLEAR on one counter index. Requesters are served round-robin, one
//   transaction is in flight at a time, and every transaction produces one
//   response on a shared channel tagged with the requester ID.
//
//   Transaction flow: IDLE (grant) -> ACCESS (bank strobes) -> RESP
//   (response held until accepted) -> IDLE.
//
// Optional feature (macro CNT_ARB_RANGE_CHK_EN):
//   When defined, an index >= N suppresses the bank strobes and returns
//   rsp_data = 0 with rsp_err = 1. When undefined, rsp_err is tied to 0 and
//   the index is driven to the bank unchecked.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [R]      per-requester request valid
//   req_ready   out  [R]      per-requester accept (one-hot or zero)
//   req_op      in   [2*R]    per-requester op: 01 READ, 10 CLEAR,
//                             11 READ_CLEAR, 00 treated as READ
//   req_idx     in   [IW*R]   per-requester counter index
//   rsp_valid   out           response valid
//   rsp_ready   in            response accept
//   rsp_id      out  [RW]     requester that issued the transaction
//   rsp_data    out  [W]      counter value before any clear (0 for CLEAR)
//   rsp_err     out           index out of range (range-check build only)
//   bank_sel    out  [IW]     counter index driven to the bank
//   bank_rd     out           read strobe to the bank
//   bank_clr    out           clear strobe to the bank
//   bank_rdata  in   [W]      combinational read data of bank_sel
// ---------------------------------------------------------------------------
module cnt_bank_arbiter #(
  parameter  int N  = 1000,
  parameter  int R  = 4,
  parameter  int W  = 32,
  localparam int IW = $clog2(N),
  localparam int RW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [2*R-1:0]  req_op,
  input  logic [IW*R-1:0] req_idx,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic [IW-1:0]   bank_sel,
  output logic            bank_rd,
  output logic            bank_clr,
  input  logic [W-1:0]    bank_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] ptr;

  logic          grant_found;
  logic [RW-1:0] grant_id;
  logic [1:0]    grant_op;
  logic [IW-1:0] grant_idx;
  logic          grant_rd;
  logic          grant_clr;
  logic          in_range;
  int            cand;

  // Round-robin search starting just after the last granted requester.
  // The candidate index wraps manually so R need not be a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    for (int i = 1; i <= R; i++) begin
      cand = int'(ptr) + i;
      if (cand >= R) cand = cand - R;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = RW'(cand);
      end
    end
  end

  assign grant_op  = req_op[int'(grant_id)*2 +: 2];
  assign grant_idx = req_idx[int'(grant_id)*IW +: IW];

  // Op 00 is reserved and behaves as a plain READ.
  assign grant_rd  = grant_op[0] | (grant_op == 2'b00);
  assign grant_clr = grant_op[1];

  // Accept is combinational in the grant cycle; it is masked during reset so
  // nothing upstream believes a request was taken while the FSM is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

`ifdef CNT_ARB_RANGE_CHK_EN
  // One extra bit so N = 2**IW still compares correctly.
  localparam logic [IW:0] N_LIM = (IW+1)'(N);

  logic err_pend;
  logic err_q;

  assign in_range = ({1'b0, grant_idx} < N_LIM);
  assign rsp_err  = err_q;

  // The range verdict is taken at grant time and published with the data at
  // the ACCESS edge, so rsp_err changes together with rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend <= 1'b0;
      err_q    <= 1'b0;
    end else if ((state == S_IDLE) && grant_found) begin
      err_pend <= !in_range;
    end else if (state == S_ACCESS) begin
      err_q <= err_pend;
    end
  end
`else
  assign in_range = 1'b1;
  assign rsp_err  = 1'b0;
`endif

  // Main FSM. Bank strobes are registered at the grant edge so they are
  // high for exactly the ACCESS cycle and drop asynchronously with reset,
  // which keeps a clear that has not reached its ACCESS edge from happening.
  // rsp_data keys off the registered read strobe: CLEAR and out-of-range
  // accesses therefore return 0 without extra decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= RW'(R-1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      bank_sel  <= '0;
      bank_rd   <= 1'b0;
      bank_clr  <= 1'b0;
    end else begin
      bank_rd  <= 1'b0;
      bank_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            ptr      <= grant_id;
            rsp_id   <= grant_id;
            bank_sel <= grant_idx;
            bank_rd  <= grant_rd & in_range;
            bank_clr <= grant_clr & in_range;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rsp_data  <= bank_rd ? bank_rdata : '0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
